// File: rtl/matrix_scan.sv
// -----------------------------------------------------------------------------
// matrix_scan
//   Column-multiplexed scan driver for a 4-column x 8-row RGB LED matrix.
//   The FSM alternates a blanking window and a drive window per column. All
//   four colour columns are snapshotted once per frame so that game-control
//   updates never tear a frame on the display.
//
//   Optional feature: define MATRIX_SCAN_PWM_EN to add a 2-bit brightness
//   input. It is sampled with the frame snapshot, and it gates the rows to the
//   first (b+1) quarters of each drive window.
//
// Parameters
//   SCAN_DIV   drive window length in clocks (multiple of 4, >= 8)
//   BLANK_CYC  blanking length in clocks before each column (>= 1)
//
// Ports
//   CLK_50M              in   system clock, rising edge
//   RST_N                in   asynchronous active-low reset
//   brightness[1:0]      in   PWM level (only with MATRIX_SCAN_PWM_EN)
//   column_0..column_3   in   24-bit colour columns, row k = bits [3k+2:3k] = {R,G,B}
//   col_sel[3:0]         out  active-low one-hot column enable
//   row_r/row_g/row_b    out  active-high row drives, bit k = row k
//   frame_start          out  one-cycle pulse on the snapshot cycle
// -----------------------------------------------------------------------------
module matrix_scan #(
    parameter int unsigned SCAN_DIV  = 12500,
    parameter int unsigned BLANK_CYC = 50
) (
    input  logic        CLK_50M,
    input  logic        RST_N,
`ifdef MATRIX_SCAN_PWM_EN
    input  logic [1:0]  brightness,
`endif
    input  logic [23:0] column_0,
    input  logic [23:0] column_1,
    input  logic [23:0] column_2,
    input  logic [23:0] column_3,
    output logic [3:0]  col_sel,
    output logic [7:0]  row_r,
    output logic [7:0]  row_g,
    output logic [7:0]  row_b,
    output logic        frame_start
);

    // One counter serves both windows, so size it for the longer one.
    localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned SNAP_W  = 96;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Current-cycle state: each clock edge executes the cycle described by
    // these registers and loads the outputs for it.
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [1:0]          idx_q,   idx_d;
    logic [SNAP_W-1:0]   snap_q,  snap_d;

    logic [3:0]          col_sel_d;
    logic [7:0]          row_r_d, row_g_d, row_b_d;
    logic                frame_start_d;

    logic                capture;
    logic [23:0]         col_data;
    logic [7:0]          col_r, col_g, col_b;
    logic                rows_en;

`ifdef MATRIX_SCAN_PWM_EN
    localparam int unsigned QUARTER = SCAN_DIV / 4;

    logic [1:0]          bright_q, bright_d;
    logic [CNT_W:0]      pwm_limit;
`endif

    // Frame snapshot happens on the first blank cycle of column 0.
    assign capture = (state_q == ST_BLANK) && (cnt_q == '0) && (idx_q == 2'd0);

    // Select the snapshot column currently being scanned.
    always_comb begin
        col_data = snap_q[23:0];
        case (idx_q)
            2'd0:    col_data = snap_q[23:0];
            2'd1:    col_data = snap_q[47:24];
            2'd2:    col_data = snap_q[71:48];
            2'd3:    col_data = snap_q[95:72];
            default: col_data = snap_q[23:0];
        endcase
    end

    // Unpack {R,G,B} triplets into per-colour row vectors.
    always_comb begin
        col_r = '0;
        col_g = '0;
        col_b = '0;
        for (int k = 0; k < 8; k++) begin
            col_r[k] = col_data[3*k + 2];
            col_g[k] = col_data[3*k + 1];
            col_b[k] = col_data[3*k];
        end
    end

`ifdef MATRIX_SCAN_PWM_EN
    // Rows lit for (b+1) quarters of the drive window; one extra bit so a
    // full-window limit equal to SCAN_DIV does not overflow.
    assign pwm_limit = (CNT_W+1)'((32'(bright_q) + 32'd1) * 32'(QUARTER));
    assign rows_en   = ({1'b0, cnt_q} < pwm_limit);
`else
    assign rows_en   = 1'b1;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        idx_d         = idx_q;
        snap_d        = snap_q;
        col_sel_d     = 4'b1111;
        row_r_d       = '0;
        row_g_d       = '0;
        row_b_d       = '0;
        frame_start_d = 1'b0;
`ifdef MATRIX_SCAN_PWM_EN
        bright_d      = bright_q;
`endif

        case (state_q)
            ST_BLANK: begin
                if (capture) begin
                    snap_d        = {column_3, column_2, column_1, column_0};
                    frame_start_d = 1'b1;
`ifdef MATRIX_SCAN_PWM_EN
                    bright_d      = brightness;
`endif
                end
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end
            end

            ST_DRIVE: begin
                col_sel_d = ~(4'b0001 << idx_q);
                if (rows_en) begin
                    row_r_d = col_r;
                    row_g_d = col_g;
                    row_b_d = col_b;
                end
                if (cnt_q == DRIVE_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                end
            end

            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
                idx_d   = 2'd0;
            end
        endcase
    end

    // State and output registers; reset blanks the matrix immediately.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            snap_q      <= '0;
            col_sel     <= 4'b1111;
            row_r       <= '0;
            row_g       <= '0;
            row_b       <= '0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            col_sel     <= col_sel_d;
            row_r       <= row_r_d;
            row_g       <= row_g_d;
            row_b       <= row_b_d;
            frame_start <= frame_start_d;
        end
    end

`ifdef MATRIX_SCAN_PWM_EN
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            bright_q <= 2'd0;
        end else begin
            bright_q <= bright_d;
        end
    end
`endif

endmodule
